// File: rtl/note_highway_if.sv
// Bus bundle for the note highway: player/RNG inputs and display/score outputs.
interface note_highway_if #(
  parameter int ROWS = 16
) ();
  logic                enable;
  logic [3:0]          rnd;
  logic [3:0]          keys;
  logic [4*ROWS-1:0]   lanes;
  logic                step;
  logic                hit;
  logic                miss;
  logic [15:0]         score;
  logic [7:0]          streak;
  logic [3:0]          misses;
  logic                game_over;

  // Game controller / stimulus side.
  modport master (
    output enable, rnd, keys,
    input  lanes, step, hit, miss, score, streak, misses, game_over
  );

  // Highway engine side.
  modport slave (
    input  enable, rnd, keys,
    output lanes, step, hit, miss, score, streak, misses, game_over
  );
endinterface

// File: rtl/note_highway.sv
// Falling-note highway: spawns notes from random nibbles, shifts them down
// every STEP_CYCLES clocks, and judges key presses against the bottom row.
module note_highway #(
  parameter int ROWS        = 16,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int MAX_MISS    = 8
) (
  input logic          clk,
  input logic          rst,
  note_highway_if.slave bus
);
  localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);
  localparam logic [3:0]    MISS_MAX = 4'(MAX_MISS);

  logic [4*ROWS-1:0] lanes_q, lanes_d, lanes_shift, hit_mask;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        hist_q, hist_d;
  logic [15:0]       score_q, score_d;
  logic [7:0]        streak_q, streak_d;
  logic [3:0]        misses_q, misses_d;
  logic              go_q, go_d, hit_q, hit_d, miss_q, miss_d;

  logic       active, step_w, row0_empty;
  logic [3:0] bottom, row0, press, hits, wrong, drops;
  logic [2:0] n_hit;
  logic [3:0] n_miss;
  logic [16:0] score_sum;
  logic [8:0]  streak_sum;
  logic [4:0]  miss_sum;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign active     = bus.enable && !go_q;
  assign step_w     = active && (timer_q == LAST);
  assign row0_empty = (row0 == 4'b0000);

  // Per-lane views of the highway, the shifted image and the hit-clear mask.
  // A new note may only enter row 0 when row 0 is empty, keeping a gap row.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bottom[gi] = lanes_q[gi*ROWS + ROWS - 1];
    assign row0[gi]   = lanes_q[gi*ROWS];
    assign lanes_shift[gi*ROWS] = row0_empty ? bus.rnd[gi] : 1'b0;
    assign hit_mask[gi*ROWS + ROWS - 1] = hits[gi];
    for (genvar gr = 1; gr < ROWS; gr++) begin : g_row
      assign lanes_shift[gi*ROWS + gr] = lanes_q[gi*ROWS + gr - 1];
      if (gr < ROWS - 1) begin : g_nomask
        assign hit_mask[gi*ROWS + gr] = 1'b0;
      end
    end
    if (ROWS > 1) begin : g_top_nomask
      assign hit_mask[gi*ROWS] = 1'b0;
    end
  end

  // Judge presses against the pre-shift bottom row; hit notes never count as drops.
  assign press  = active ? (bus.keys & ~hist_q) : 4'b0000;
  assign hits   = press & bottom;
  assign wrong  = press & ~bottom;
  assign drops  = step_w ? (bottom & ~hits) : 4'b0000;
  assign n_hit  = pop4(hits);
  assign n_miss = {1'b0, pop4(wrong)} + {1'b0, pop4(drops)};
  assign score_sum  = {1'b0, score_q} + {14'd0, n_hit};
  assign streak_sum = {1'b0, streak_q} + {6'd0, n_hit};
  assign miss_sum   = {1'b0, misses_q} + {1'b0, n_miss};

  // Next-state: everything holds and pulses drop when the game is inactive.
  always_comb begin
    lanes_d  = lanes_q;
    timer_d  = timer_q;
    hist_d   = hist_q;
    score_d  = score_q;
    streak_d = streak_q;
    misses_d = misses_q;
    go_d     = go_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (active) begin
      hist_d  = bus.keys;
      timer_d = step_w ? '0 : timer_q + 1'b1;
      lanes_d = step_w ? lanes_shift : (lanes_q & ~hit_mask);
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      if (n_miss != 4'd0) streak_d = 8'd0;
      else                streak_d = streak_sum[8] ? 8'hFF : streak_sum[7:0];
      misses_d = (miss_sum >= {1'b0, MISS_MAX}) ? MISS_MAX : miss_sum[3:0];
      go_d     = go_q || (misses_d == MISS_MAX);
      hit_d    = (n_hit != 3'd0);
      miss_d   = (n_miss != 4'd0);
    end
  end

  // State registers; key history starts all-ones so held keys are not presses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q  <= '0;
      timer_q  <= '0;
      hist_q   <= 4'b1111;
      score_q  <= '0;
      streak_q <= '0;
      misses_q <= '0;
      go_q     <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      lanes_q  <= lanes_d;
      timer_q  <= timer_d;
      hist_q   <= hist_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      misses_q <= misses_d;
      go_q     <= go_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.lanes     = lanes_q;
  assign bus.step      = step_w;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.score     = score_q;
  assign bus.streak    = streak_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = go_q;
endmodule

// File: tb/tb_note_highway.sv
// Bench for note_highway: directed game scenario plus randomized play,
// checked against a row/lane array model of the highway rules.
module tb_note_highway;
  localparam int R  = 4;
  localparam int S  = 4;
  localparam int MM = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  note_highway_if #(.ROWS(R)) nh_if ();
  note_highway #(.ROWS(R), .STEP_CYCLES(S), .MAX_MISS(MM)) dut (
    .clk(clk), .rst(rst), .bus(nh_if.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: one nibble per row (bit i = lane i), integer counters.
  logic [3:0] m_hw [R];
  int         m_tmr, m_score, m_streak, m_misses;
  bit         m_go, m_hit, m_miss, last_step;
  logic [3:0] m_hist;

  logic       en_v;
  logic [3:0] rnd_v, keys_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*R-1:0] m_lanes();
    logic [4*R-1:0] v;
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < R; r++) v[l*R + r] = m_hw[r][l];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < R; r++) m_hw[r] = 4'b0000;
    m_tmr = 0; m_score = 0; m_streak = 0; m_misses = 0;
    m_go = 0; m_hit = 0; m_miss = 0; m_hist = 4'b1111;
  endtask

  task automatic model_update();
    int nh, nm;
    bit empty0;
    nh = 0; nm = 0;
    if (!(en_v && !m_go)) begin
      m_hit = 0; m_miss = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (keys_v[i] && !m_hist[i]) begin
        if (m_hw[R-1][i]) begin m_hw[R-1][i] = 1'b0; nh++; end
        else nm++;
      end
    end
    if (m_tmr == S - 1) begin
      for (int i = 0; i < 4; i++) nm += int'(m_hw[R-1][i]);
      empty0 = (m_hw[0] == 4'b0000);
      for (int r = R - 1; r > 0; r--) m_hw[r] = m_hw[r-1];
      m_hw[0] = empty0 ? rnd_v : 4'b0000;
      m_tmr = 0;
    end else begin
      m_tmr++;
    end
    m_score  = (m_score + nh > 65535) ? 65535 : m_score + nh;
    m_streak = (nm > 0) ? 0 : ((m_streak + nh > 255) ? 255 : m_streak + nh);
    m_misses = (m_misses + nm > MM) ? MM : m_misses + nm;
    if (m_misses == MM) m_go = 1;
    m_hist = keys_v;
    m_hit  = (nh > 0);
    m_miss = (nm > 0);
  endtask

  task automatic check_all();
    chk("lanes",     nh_if.lanes,     m_lanes());
    chk("hit",       nh_if.hit,       m_hit);
    chk("miss",      nh_if.miss,      m_miss);
    chk("score",     nh_if.score,     m_score);
    chk("streak",    nh_if.streak,    m_streak);
    chk("misses",    nh_if.misses,    m_misses);
    chk("game_over", nh_if.game_over, m_go);
  endtask

  // One clock: drive inputs, check the combinational step, advance model, check state.
  task automatic cycle();
    bit exp_step;
    nh_if.enable = en_v; nh_if.rnd = rnd_v; nh_if.keys = keys_v;
    #1;
    exp_step = en_v && !m_go && (m_tmr == S - 1);
    chk("step", nh_if.step, exp_step);
    model_update();
    last_step = exp_step;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input logic [3:0] k);
    keys_v = k; en_v = 1'b0;
    nh_if.enable = 1'b0; nh_if.keys = k; nh_if.rnd = rnd_v;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_step", nh_if.step, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  task automatic run_to_step();
    bit got;
    got = 0;
    for (int c = 0; c < 2 * S && !got; c++) begin
      cycle();
      got = last_step;
    end
    chk("step_within_budget", got, 1'b1);
  endtask

  initial begin
    logic [4*R-1:0] frozen_lanes;
    int frozen_score, sel;
    en_v = 0; rnd_v = 4'b0101; keys_v = 4'b1111;
    nh_if.enable = 0; nh_if.rnd = rnd_v; nh_if.keys = keys_v;
    @(negedge clk);

    // Reset with keys held: all zero, and held keys never register.
    do_reset(4'b1111);
    chk("rst_score", nh_if.score, 16'd0);
    chk("rst_lanes", nh_if.lanes, '0);
    en_v = 1; rnd_v = 4'b0101;
    for (int c = 0; c < S; c++) begin
      cycle();
      chk("held_hit", nh_if.hit, 1'b0);
      chk("held_miss", nh_if.miss, 1'b0);
    end
    chk("spawn_row0_s1", nh_if.lanes[0], 1'b1);

    // Spawn/gap: lane 0 row 0 alternates, lane 1 stays empty.
    keys_v = 4'b0000;
    for (int s = 2; s <= 4; s++) begin
      run_to_step();
      chk("spawn_row0", nh_if.lanes[0], logic'(s % 2));
      chk("lane1_empty", nh_if.lanes[2*R-1:R], '0);
    end

    // Hit on lane 2 bottom row.
    keys_v = 4'b0100; cycle();
    chk("hit_pulse", nh_if.hit, 1'b1);
    chk("hit_score", nh_if.score, 16'd1);
    chk("hit_streak", nh_if.streak, 8'd1);
    chk("hit_cleared", nh_if.lanes[2*R + R - 1], 1'b0);
    keys_v = 4'b0000;

    // Lane 0 note drops out, then a wrong press on an empty bottom row.
    run_to_step();
    chk("drop_misses", nh_if.misses, 4'd1);
    chk("drop_miss", nh_if.miss, 1'b1);
    chk("drop_streak", nh_if.streak, 8'd0);
    keys_v = 4'b1000; cycle();
    chk("wrong_misses", nh_if.misses, 4'd2);
    keys_v = 4'b0000; cycle();
    run_to_step();

    // Press exactly on the step cycle: judged pre-shift, no drop counted.
    for (int c = 0; c < S && m_tmr != S - 1; c++) cycle();
    keys_v = 4'b0101; cycle();
    chk("same_cycle_step", last_step, 1'b1);
    chk("same_cycle_hit", nh_if.hit, 1'b1);
    chk("same_cycle_score", nh_if.score, 16'd3);
    chk("same_cycle_misses", nh_if.misses, 4'd2);
    keys_v = 4'b0000;

    // Two notes fall out together: misses saturate and the game ends.
    run_to_step();
    run_to_step();
    chk("go_flag", nh_if.game_over, 1'b1);
    chk("go_misses", nh_if.misses, 4'(MM));

    // Frozen for 20 steps' worth of cycles despite activity.
    frozen_lanes = m_lanes();
    frozen_score = m_score;
    for (int c = 0; c < 20 * S; c++) begin
      rnd_v = 4'($urandom); keys_v = 4'($urandom);
      cycle();
    end
    chk("frozen_lanes", nh_if.lanes, frozen_lanes);
    chk("frozen_score", nh_if.score, frozen_score);
    do_reset(4'b0000);
    chk("post_rst_go", nh_if.game_over, 1'b0);
    chk("post_rst_misses", nh_if.misses, 4'd0);

    // Randomized games against the model.
    for (int g = 0; g < 5; g++) begin
      do_reset(4'($urandom));
      for (int c = 0; c < 600; c++) begin
        en_v  = ($urandom_range(0, 9) != 0);
        rnd_v = 4'($urandom);
        sel   = $urandom_range(0, 9);
        if (sel >= 4 && sel <= 5)      keys_v = 4'b0000;
        else if (sel >= 6 && sel <= 8) keys_v = m_hw[R-1];
        else if (sel == 9)             keys_v = 4'($urandom);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
